// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and reset values for the processor memory-port arbiter and its
// tag-owner table.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef enum logic {
    REQ_DCACHE = 1'b0,
    REQ_ICACHE = 1'b1
  } REQ_ID_t;

  localparam int unsigned MEM_TAG_W = 4;

  typedef struct packed {
    logic [1:0]  command;
    logic [63:0] addr;
    logic [63:0] data;
  } MEM_REQ_t;

  typedef struct packed {
    logic [MEM_TAG_W-1:0] response;
    logic [MEM_TAG_W-1:0] tag;
    logic [63:0]          data;
  } MEM_RSP_t;

  localparam logic    TAG_VALID_RESET = 1'b0;
  localparam REQ_ID_t TAG_OWNER_RESET = REQ_DCACHE;

  function automatic REQ_ID_t rr_reset_value(input int unsigned rr_init);
    return (rr_init == 0) ? REQ_DCACHE : REQ_ICACHE;
  endfunction

endpackage

// File: rtl/mem_tag_owner_table.sv
// Per-tag valid/owner storage for outstanding loads. A set and a clear of the
// same entry in one cycle leaves the entry valid with the new owner.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned NUM_TAGS = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  REQ_ID_t          set_owner,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_valid,
  output REQ_ID_t          lookup_owner
);

  logic [NUM_TAGS-1:0] valid;
  REQ_ID_t             owner [NUM_TAGS];

  // Clear is issued before set so the later NBA gives the set priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= {NUM_TAGS{TAG_VALID_RESET}};
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        owner[i] <= TAG_OWNER_RESET;
      end
    end else begin
      if (clr_en && clr_tag != '0) begin
        valid[clr_tag] <= 1'b0;
      end
      if (set_en && set_tag != '0) begin
        valid[set_tag] <= 1'b1;
        owner[set_tag] <= set_owner;
      end
    end
  end

  always_comb begin
    lookup_valid = (lookup_tag != '0) && valid[lookup_tag];
    lookup_owner = owner[lookup_tag];
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the processor memory port between the Dcache and Icache controllers,
// routing tagged load returns back to whichever side issued the load.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned NUM_TAGS = 16,
  parameter int unsigned RR_INIT  = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       dc_command,
  input  logic [63:0]      dc_addr,
  input  logic [63:0]      dc_data,
  output logic [TAG_W-1:0] dc_response,
  output logic [TAG_W-1:0] dc_tag,
  output logic [63:0]      dc_data_out,
  input  logic [1:0]       ic_command,
  input  logic [63:0]      ic_addr,
  input  logic [63:0]      ic_data,
  output logic [TAG_W-1:0] ic_response,
  output logic [TAG_W-1:0] ic_tag,
  output logic [63:0]      ic_data_out,
  output logic [1:0]       proc2mem_command,
  output logic [63:0]      proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [TAG_W-1:0] mem2proc_tag,
  input  logic [63:0]      mem2proc_data,
  input  logic             drain_ic,
  output logic             mem_idle,
  output logic             unowned_tag_err
);

  localparam logic [4:0] OUT_MAX = 5'(NUM_TAGS - 1);

  REQ_ID_t    rr_ptr;
  logic [4:0] outstanding;

  logic       dc_req, ic_req, contested;
  logic       grant_dc, grant_ic, granted;
  logic       accepted, accept_load;
  REQ_ID_t    grant_id;
  MEM_REQ_t   dc_req_bus, ic_req_bus, fwd_req;

  logic       tag_nz, route_hit;
  logic       lookup_valid;
  REQ_ID_t    lookup_owner;

  always_comb begin
    dc_req    = (dc_command != BUS_NONE);
    ic_req    = (ic_command != BUS_NONE) && !drain_ic;
    contested = dc_req && ic_req;
    grant_dc  = dc_req && (!ic_req || rr_ptr == REQ_DCACHE);
    grant_ic  = ic_req && (!dc_req || rr_ptr == REQ_ICACHE);
    granted   = grant_dc || grant_ic;
    grant_id  = grant_ic ? REQ_ICACHE : REQ_DCACHE;
  end

  always_comb begin
    dc_req_bus = '{command: dc_command, addr: dc_addr, data: dc_data};
    ic_req_bus = '{command: ic_command, addr: ic_addr, data: ic_data};
    fwd_req    = '0;
    if (grant_dc) begin
      fwd_req = dc_req_bus;
    end else if (grant_ic) begin
      fwd_req = ic_req_bus;
    end
    proc2mem_command = fwd_req.command;
    proc2mem_addr    = fwd_req.addr;
    proc2mem_data    = fwd_req.data;
  end

  // Responses are forced low while reset is held so neither cache sees an
  // acceptance the table cannot record.
  always_comb begin
    dc_response = '0;
    ic_response = '0;
    if (reset_n) begin
      if (grant_dc) dc_response = mem2proc_response;
      if (grant_ic) ic_response = mem2proc_response;
    end
    accepted    = granted && (mem2proc_response != '0);
    accept_load = accepted && (fwd_req.command == BUS_LOAD);
  end

  mem_tag_owner_table #(
    .TAG_W    (TAG_W),
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_table (
    .clock        (clock),
    .reset_n      (reset_n),
    .set_en       (accept_load),
    .set_tag      (mem2proc_response),
    .set_owner    (grant_id),
    .clr_en       (route_hit),
    .clr_tag      (mem2proc_tag),
    .lookup_tag   (mem2proc_tag),
    .lookup_valid (lookup_valid),
    .lookup_owner (lookup_owner)
  );

  always_comb begin
    tag_nz      = (mem2proc_tag != '0);
    route_hit   = tag_nz && lookup_valid;
    dc_tag      = '0;
    dc_data_out = '0;
    ic_tag      = '0;
    ic_data_out = '0;
    if (route_hit) begin
      if (lookup_owner == REQ_ICACHE) begin
        ic_tag      = mem2proc_tag;
        ic_data_out = mem2proc_data;
      end else begin
        dc_tag      = mem2proc_tag;
        dc_data_out = mem2proc_data;
      end
    end
    mem_idle = (outstanding == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= rr_reset_value(RR_INIT);
    end else if (contested && accepted) begin
      rr_ptr <= grant_ic ? REQ_DCACHE : REQ_ICACHE;
    end
  end

  // A load accepted and a return routed in the same cycle cancel out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else if (accept_load && !route_hit) begin
      if (outstanding != OUT_MAX) outstanding <= outstanding + 5'd1;
    end else if (!accept_load && route_hit) begin
      if (outstanding != '0) outstanding <= outstanding - 5'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      unowned_tag_err <= 1'b0;
    end else if (tag_nz && !lookup_valid) begin
      unowned_tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a random
// run compared against a tag-map reference model.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  dc_command, ic_command;
  logic [63:0] dc_addr, dc_data, ic_addr, ic_data;
  logic [3:0]  dc_response, dc_tag, ic_response, ic_tag;
  logic [63:0] dc_data_out, ic_data_out;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr, proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic        drain_ic, mem_idle, unowned_tag_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner per tag (-1 = none), round-robin favourite,
  // outstanding load count and the sticky error.
  int owner_m [16];
  int rr_m;
  int outs_m;
  bit err_m;

  mem_bus_arbiter #(.TAG_W(4), .NUM_TAGS(16), .RR_INIT(0)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .dc_command        (dc_command),
    .dc_addr           (dc_addr),
    .dc_data           (dc_data),
    .dc_response       (dc_response),
    .dc_tag            (dc_tag),
    .dc_data_out       (dc_data_out),
    .ic_command        (ic_command),
    .ic_addr           (ic_addr),
    .ic_data           (ic_data),
    .ic_response       (ic_response),
    .ic_tag            (ic_tag),
    .ic_data_out       (ic_data_out),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_tag      (mem2proc_tag),
    .mem2proc_data     (mem2proc_data),
    .drain_ic          (drain_ic),
    .mem_idle          (mem_idle),
    .unowned_tag_err   (unowned_tag_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    foreach (owner_m[i]) owner_m[i] = -1;
    rr_m   = 0;
    outs_m = 0;
    err_m  = 0;
  endfunction

  function automatic int model_winner(input logic [1:0] dcc, input logic [1:0] icc, input logic drn);
    bit d = (dcc != 2'd0);
    bit i = (icc != 2'd0) && !drn;
    if (d && i) return rr_m;
    if (d) return 0;
    if (i) return 1;
    return -1;
  endfunction

  task automatic idle_inputs();
    dc_command = 2'd0; dc_addr = '0; dc_data = '0;
    ic_command = 2'd0; ic_addr = '0; ic_data = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    drain_ic = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    dc_command = 2'd1; mem2proc_response = 4'd3; mem2proc_tag = 4'd3;
    #3;
    n_checks++; if (mem_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", mem_idle); end
    n_checks++; if (dc_response !== 4'd0) begin n_fail++; $display("FAIL reset_dc_response: got %0d want 0", dc_response); end
    n_checks++; if ({dc_tag, ic_tag} !== 8'd0) begin n_fail++; $display("FAIL reset_tags: got %h want 00", {dc_tag, ic_tag}); end
    n_checks++; if (unowned_tag_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", unowned_tag_err); end
    do_reset();
    #1;
    n_checks++; if (proc2mem_command !== 2'd0 || proc2mem_addr !== 64'd0) begin n_fail++; $display("FAIL idle_bus: cmd %0d addr %h want 0 0", proc2mem_command, proc2mem_addr); end
    n_checks++; if (mem_idle !== 1'b1 || unowned_tag_err !== 1'b0) begin n_fail++; $display("FAIL post_reset: idle %b err %b want 1 0", mem_idle, unowned_tag_err); end
  endtask

  task automatic test_single_load();
    do_reset();
    dc_command = 2'd1; dc_addr = 64'h100; mem2proc_response = 4'd3;
    #1;
    n_checks++; if (proc2mem_addr !== 64'h100 || proc2mem_command !== 2'd1) begin n_fail++; $display("FAIL single_fwd: addr %h cmd %0d want 100 1", proc2mem_addr, proc2mem_command); end
    n_checks++; if (dc_response !== 4'd3 || ic_response !== 4'd0) begin n_fail++; $display("FAIL single_rsp: dc %0d ic %0d want 3 0", dc_response, ic_response); end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++; if (mem_idle !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", mem_idle); end
    next_cycle();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hABCD;
    #1;
    n_checks++; if (dc_tag !== 4'd3 || dc_data_out !== 64'hABCD) begin n_fail++; $display("FAIL single_ret: tag %0d data %h want 3 abcd", dc_tag, dc_data_out); end
    n_checks++; if (ic_tag !== 4'd0 || ic_data_out !== 64'd0) begin n_fail++; $display("FAIL single_ic_quiet: tag %0d data %h want 0 0", ic_tag, ic_data_out); end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++; if (mem_idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b want 1", mem_idle); end
  endtask

  task automatic test_round_robin();
    bit exp_dc [6]     = '{1, 0, 1, 0, 1, 1};
    logic [3:0] rsp[6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd5};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      dc_command = 2'd1; dc_addr = 64'h200;
      ic_command = 2'd1; ic_addr = 64'h300;
      mem2proc_response = rsp[k];
      #1;
      n_checks++;
      if (proc2mem_addr !== (exp_dc[k] ? 64'h200 : 64'h300)) begin
        n_fail++; $display("FAIL rr_grant[%0d]: addr %h want %h", k, proc2mem_addr, exp_dc[k] ? 64'h200 : 64'h300);
      end
      n_checks++;
      if (dc_response !== (exp_dc[k] ? rsp[k] : 4'd0) || ic_response !== (exp_dc[k] ? 4'd0 : rsp[k])) begin
        n_fail++; $display("FAIL rr_rsp[%0d]: dc %0d ic %0d resp %0d", k, dc_response, ic_response, rsp[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_drain_ic();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      dc_command = 2'd1; dc_addr = 64'h400;
      ic_command = 2'd1; ic_addr = 64'h500;
      drain_ic = (k != 4);
      mem2proc_response = 4'(k);
      #1;
      n_checks++;
      if (proc2mem_addr !== 64'h400 || ic_response !== 4'd0 || dc_response !== 4'(k)) begin
        n_fail++; $display("FAIL drain[%0d]: addr %h dc %0d ic %0d want 400 %0d 0", k, proc2mem_addr, dc_response, ic_response, k);
      end
      next_cycle();
    end
  endtask

  task automatic test_store_unowned();
    do_reset();
    dc_command = 2'd2; dc_data = 64'h55; mem2proc_response = 4'd5;
    #1;
    n_checks++; if (dc_response !== 4'd5 || proc2mem_command !== 2'd2 || proc2mem_data !== 64'h55) begin n_fail++; $display("FAIL store_fwd: rsp %0d cmd %0d data %h", dc_response, proc2mem_command, proc2mem_data); end
    next_cycle();
    idle_inputs();
    mem2proc_tag = 4'd5; mem2proc_data = 64'h99;
    #1;
    n_checks++; if (mem_idle !== 1'b1) begin n_fail++; $display("FAIL store_idle: got %b want 1", mem_idle); end
    n_checks++; if (dc_tag !== 4'd0 || ic_tag !== 4'd0) begin n_fail++; $display("FAIL store_route: dc %0d ic %0d want 0 0", dc_tag, ic_tag); end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++; if (unowned_tag_err !== 1'b1) begin n_fail++; $display("FAIL store_err: got %b want 1", unowned_tag_err); end
  endtask

  task automatic test_same_tag_collision();
    do_reset();
    ic_command = 2'd1; ic_addr = 64'h700; mem2proc_response = 4'd7;
    next_cycle();
    idle_inputs();
    dc_command = 2'd1; dc_addr = 64'h708; mem2proc_response = 4'd7;
    mem2proc_tag = 4'd7; mem2proc_data = 64'h77;
    #1;
    n_checks++; if (ic_tag !== 4'd7 || ic_data_out !== 64'h77 || dc_tag !== 4'd0) begin n_fail++; $display("FAIL coll_ret: ic %0d %h dc %0d", ic_tag, ic_data_out, dc_tag); end
    n_checks++; if (dc_response !== 4'd7) begin n_fail++; $display("FAIL coll_accept: got %0d want 7", dc_response); end
    next_cycle();
    idle_inputs();
    mem2proc_tag = 4'd7; mem2proc_data = 64'h88;
    #1;
    n_checks++; if (dc_tag !== 4'd7 || dc_data_out !== 64'h88 || ic_tag !== 4'd0) begin n_fail++; $display("FAIL coll_new_owner: dc %0d %h ic %0d", dc_tag, dc_data_out, ic_tag); end
    n_checks++; if (mem_idle !== 1'b0) begin n_fail++; $display("FAIL coll_busy: got %b want 0", mem_idle); end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++; if (mem_idle !== 1'b1 || unowned_tag_err !== 1'b0) begin n_fail++; $display("FAIL coll_count: idle %b err %b want 1 0", mem_idle, unowned_tag_err); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      idle_inputs();
      if (k == 3) begin ic_command = 2'd1; end else begin dc_command = 2'd1; end
      mem2proc_response = 4'(k);
      next_cycle();
    end
    idle_inputs();
    dc_command = 2'd1; mem2proc_response = 4'd4;
    #1;
    n_checks++; if (mem_idle !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", mem_idle); end
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (mem_idle !== 1'b1 || dc_response !== 4'd0) begin n_fail++; $display("FAIL mid_reset: idle %b rsp %0d want 1 0", mem_idle, dc_response); end
    idle_inputs();
    @(posedge clock);
    #2 reset_n = 1'b1;
    next_cycle();
    mem2proc_tag = 4'd2; mem2proc_data = 64'h22;
    #1;
    n_checks++; if (dc_tag !== 4'd0 || ic_tag !== 4'd0) begin n_fail++; $display("FAIL mid_drop: dc %0d ic %0d want 0 0", dc_tag, ic_tag); end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++; if (unowned_tag_err !== 1'b1) begin n_fail++; $display("FAIL mid_err: got %b want 1", unowned_tag_err); end
  endtask

  task automatic test_random();
    int win, otag, net;
    int live[$];
    logic [1:0]  e_cmd;
    logic [63:0] e_addr, e_data;
    logic [3:0]  e_dc_rsp, e_ic_rsp, e_dc_tag, e_ic_tag;
    logic [63:0] e_dc_do, e_ic_do;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      dc_command = 2'($urandom_range(0, 2));
      ic_command = 2'($urandom_range(0, 2));
      dc_addr = {$urandom, $urandom} & ~64'h7;
      ic_addr = {$urandom, $urandom} & ~64'h7;
      dc_data = {$urandom, $urandom};
      ic_data = {$urandom, $urandom};
      drain_ic = ($urandom_range(0, 5) == 0);
      mem2proc_response = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mem2proc_data = {$urandom, $urandom};
      live.delete();
      foreach (owner_m[t]) if (owner_m[t] >= 0) live.push_back(t);
      if (live.size() > 0 && $urandom_range(0, 1) == 1)
        mem2proc_tag = 4'(live[$urandom_range(0, live.size() - 1)]);
      else if ($urandom_range(0, 7) == 0)
        mem2proc_tag = 4'($urandom_range(1, 15));
      else
        mem2proc_tag = 4'd0;
      #1;
      win = model_winner(dc_command, ic_command, drain_ic);
      e_cmd = (win == 0) ? dc_command : (win == 1) ? ic_command : 2'd0;
      e_addr = (win == 0) ? dc_addr : (win == 1) ? ic_addr : 64'd0;
      e_data = (win == 0) ? dc_data : (win == 1) ? ic_data : 64'd0;
      e_dc_rsp = (win == 0) ? mem2proc_response : 4'd0;
      e_ic_rsp = (win == 1) ? mem2proc_response : 4'd0;
      otag = (mem2proc_tag != 0) ? owner_m[mem2proc_tag] : -1;
      e_dc_tag = (otag == 0) ? mem2proc_tag : 4'd0;
      e_ic_tag = (otag == 1) ? mem2proc_tag : 4'd0;
      e_dc_do = (otag == 0) ? mem2proc_data : 64'd0;
      e_ic_do = (otag == 1) ? mem2proc_data : 64'd0;
      n_checks++;
      if ({proc2mem_command, proc2mem_addr, proc2mem_data} !== {e_cmd, e_addr, e_data}) begin
        n_fail++; $display("FAIL rand_fwd[%0d]: cmd %0d addr %h data %h want %0d %h %h", cyc, proc2mem_command, proc2mem_addr, proc2mem_data, e_cmd, e_addr, e_data);
      end
      n_checks++;
      if (dc_response !== e_dc_rsp || ic_response !== e_ic_rsp) begin
        n_fail++; $display("FAIL rand_rsp[%0d]: dc %0d ic %0d want %0d %0d", cyc, dc_response, ic_response, e_dc_rsp, e_ic_rsp);
      end
      n_checks++;
      if ({dc_tag, ic_tag, dc_data_out, ic_data_out} !== {e_dc_tag, e_ic_tag, e_dc_do, e_ic_do}) begin
        n_fail++; $display("FAIL rand_route[%0d]: dc %0d/%h ic %0d/%h want %0d/%h %0d/%h", cyc, dc_tag, dc_data_out, ic_tag, ic_data_out, e_dc_tag, e_dc_do, e_ic_tag, e_ic_do);
      end
      n_checks++;
      if (mem_idle !== (outs_m == 0) || unowned_tag_err !== err_m) begin
        n_fail++; $display("FAIL rand_status[%0d]: idle %b err %b want %b %b", cyc, mem_idle, unowned_tag_err, outs_m == 0, err_m);
      end
      net = 0;
      if (mem2proc_tag != 0) begin
        if (otag >= 0) begin owner_m[mem2proc_tag] = -1; net--; end
        else err_m = 1;
      end
      if (win >= 0 && mem2proc_response != 0) begin
        if (e_cmd == 2'd1) begin owner_m[mem2proc_response] = win; net++; end
        if (dc_command != 0 && ic_command != 0 && !drain_ic) rr_m = 1 - win;
      end
      if (net > 0 && outs_m < 15) outs_m++;
      if (net < 0 && outs_m > 0) outs_m--;
      next_cycle();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_load();
    test_round_robin();
    test_drain_ic();
    test_store_unowned();
    test_same_tag_collision();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single processor memory port between the Dcache controller (MSHR side) and the Icache controller.
- Each cycle it grants at most one requester, forwards that requester's command/addr/data to memory and returns the memory response only to the granted side.
- A tag-owner table records which requester owns each accepted load tag, so returning tagged data reaches the correct requester.
- Sits between both cache controllers and the top-level proc2mem/mem2proc pins.

Parameters:
- TAG_W, 4, width of memory response/tag fields; tag 0 means "none".
- NUM_TAGS, 16, tag-owner table depth (2**TAG_W); entry 0 is never written.
- RR_INIT, 0, reset value of round-robin pointer (0 = Dcache favoured first, 1 = Icache).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dc_command  in  2  Dcache request: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2.
- dc_addr  in  64  Dcache request address, 8-byte aligned.
- dc_data  in  64  Dcache store data.
- dc_response  out  TAG_W  memory response to Dcache; 0 = not accepted.
- dc_tag  out  TAG_W  returning tag routed to Dcache; 0 = none.
- dc_data_out  out  64  returning data routed to Dcache.
- ic_command, ic_addr, ic_data, ic_response, ic_tag, ic_data_out: same as the dc_* ports, for the Icache.
- proc2mem_command  out  2  to memory.
- proc2mem_addr  out  64  to memory.
- proc2mem_data  out  64  to memory.
- mem2proc_response  in  TAG_W  memory acceptance tag, same cycle as the request.
- mem2proc_tag  in  TAG_W  tag of the data returning this cycle.
- mem2proc_data  in  64  returning data.
- drain_ic  in  1  blocks new Icache grants (used during Dcache write-back flush).
- mem_idle  out  1  no load tags outstanding.
- unowned_tag_err  out  1  sticky: a nonzero tag returned with no valid owner.

Behaviour:
- Arbitration (combinational):
  - dc_req = dc_command != BUS_NONE.
  - ic_req = ic_command != BUS_NONE and !drain_ic.
  - If only one side requests, that side is granted.
  - If both request, the side selected by rr_ptr is granted (0 = Dcache, 1 = Icache).
  - If neither requests, proc2mem_command = BUS_NONE and proc2mem_addr/data = 0.
- Forwarding:
  - The granted side's command/addr/data drive proc2mem_*.
  - granted_response = mem2proc_response.
  - The non-granted side's response is forced to 0, and that side must retry next cycle.
- rr_ptr:
  - Updates only when a grant was contested (both requesting) and accepted (mem2proc_response != 0); it then points to the loser.
  - A rejected grant (response 0) leaves rr_ptr unchanged.
- Tag table:
  - Registers valid[NUM_TAGS] and owner[NUM_TAGS] (0 = Dcache, 1 = Icache).
  - On an accepted BUS_LOAD, the entry at mem2proc_response is set valid with the granted owner.
  - BUS_STORE acceptances are not recorded.
- Return routing (combinational):
  - If mem2proc_tag != 0 and valid[tag], the owner's *_tag gets mem2proc_tag and its *_data_out gets mem2proc_data; the other side sees tag 0 and data 0.
  - The entry is cleared at the next edge.
  - If mem2proc_tag != 0 and the entry is invalid, nothing is routed and unowned_tag_err is set (sticky until reset).
- Simultaneous return and new acceptance on the same tag number in one cycle: the set wins (entry stays valid with the new owner).
- Outstanding count:
  - outstanding is a 5-bit counter: +1 per accepted load, −1 per routed return, net change when both occur in the same cycle.
  - mem_idle = (outstanding == 0).
  - It saturates at NUM_TAGS−1 and never underflows.
- Reset (asynchronous, any time):
  - valid cleared; rr_ptr = RR_INIT; outstanding = 0; unowned_tag_err = 0.
  - Combinational outputs follow inputs immediately: mem_idle = 1, all responses/tags = 0 while reset_n is low.
  - Tags returning after reset are dropped and flag unowned_tag_err.
- Latency: zero-cycle request pass-through; the owner table updates one edge after acceptance.

Decomposition:
- Shared package:
  - BUS_COMMAND enum (BUS_NONE/BUS_LOAD/BUS_STORE).
  - MEM_REQ_t struct {command, addr, data}.
  - MEM_RSP_t struct {response, tag, data}.
  - REQ_ID_t enum {REQ_DCACHE, REQ_ICACHE}.
  - Reset-value macros for the table and rr_ptr.
- One sub-module, mem_tag_owner_table: set port, clear port, lookup port, set-wins rule, valid/owner storage.
- Arbitration, forwarding and the counter stay in mem_bus_arbiter.

Test Plan:
- Only dc_command = LOAD, addr 0x100, mem2proc_response = 3 → proc2mem_addr 0x100, dc_response 3, ic_response 0; two cycles later mem2proc_tag = 3, data 0xABCD → dc_tag 3, dc_data_out 0xABCD, ic_tag 0, mem_idle back to 1.
- Both sides request LOAD every cycle with responses 1, 2, 3, 4 → grants alternate D, I, D, I; a response-0 cycle repeats the same grant.
- drain_ic = 1 with both requesting → Dcache granted every cycle; ic_response 0; rr_ptr unchanged.
- Accepted STORE with response 5, then mem2proc_tag = 5 → nothing routed, unowned_tag_err = 1.
- Tag 7 returns (owner Icache) in the same cycle that a Dcache load is accepted with tag 7 → Icache receives the return; entry 7 ends valid with owner Dcache; outstanding unchanged.
- Reset_n pulsed low mid-flight with 3 tags outstanding → mem_idle = 1 immediately; a later return of an old tag raises unowned_tag_err.
